// File: rtl/uart_pkg.sv
// Shared constants, divisor type and default-divisor helper for the UART baud generator.
package uart_pkg;

   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DIV_W      = 16;

   typedef logic [UART_DIV_W-1:0] uart_div_t;

   // A divisor below one sys_clk per oversample period is meaningless, so clamp to 1.
   function automatic int unsigned calc_div(input int unsigned sys_freq,
                                            input int unsigned baud,
                                            input int unsigned os);
      int unsigned den;
      den = baud * os;
      if (den == 32'd0) begin
         return 32'd1;
      end else if (sys_freq < den) begin
         return 32'd1;
      end else begin
         return sys_freq / den;
      end
   endfunction

endpackage

// File: rtl/uart_mod_counter.sv
// Modulus counter: counts 0..last while enabled, sync clear, combinational terminal indication.
module uart_mod_counter
   import uart_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         sys_clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] last,
   output logic         term
);

   logic [W-1:0] cnt_r;

   // >= rather than == so a count never runs past a shrunken modulus
   assign term = en & (cnt_r >= last);

   // Count state: reset and clear beat counting, wrap at the terminal value.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         cnt_r <= {W{1'b0}};
      end else if (clr) begin
         cnt_r <= {W{1'b0}};
      end else if (term) begin
         cnt_r <= {W{1'b0}};
      end else if (en) begin
         cnt_r <= cnt_r + W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/uart_baud_gen.sv
// Programmable oversample/bit tick generator for the UART Tx and Rx paths.
// Define UART_BAUD_FRAC_EN to build the fractional divisor accumulator.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int SYS_CLK_FREQ = 200_000_000,
   parameter int DEFAULT_BAUD = 19200,
   parameter int OVERSAMPLE   = UART_OVERSAMPLE,
   parameter int DIV_W        = UART_DIV_W,
   parameter int FRAC_W       = 4
) (
   input  logic              sys_clk,
   input  logic              reset,
   input  logic              en,
   input  logic              div_ld,
   input  logic [DIV_W-1:0]  div_in,
   input  logic [FRAC_W-1:0] frac_in,
   output logic              os_tick,
   output logic              bit_tick,
   output logic [DIV_W-1:0]  div_cur
);

   localparam int               BIT_W    = $clog2(OVERSAMPLE);
   localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(calc_div(SYS_CLK_FREQ, DEFAULT_BAUD, OVERSAMPLE));
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OVERSAMPLE - 1);

   logic [DIV_W-1:0] div_cur_r;
   logic [DIV_W-1:0] div_load_val_s;
   logic [DIV_W-1:0] os_last_s;
   logic             os_term_s;
   logic             bit_term_s;
   logic             os_tick_r;
   logic             bit_tick_r;

   // A zero divisor would never reach terminal count, so load it as 1.
   always_comb begin
      div_load_val_s = div_in;
      if (div_in == {DIV_W{1'b0}}) begin
         div_load_val_s = DIV_W'(1);
      end else begin
         div_load_val_s = div_in;
      end
   end

`ifdef UART_BAUD_FRAC_EN
   logic [FRAC_W-1:0] frac_cur_r;
   logic [FRAC_W-1:0] frac_acc_r;
   logic              stretch_r;
   logic [FRAC_W:0]   frac_sum_s;

   assign frac_sum_s = {1'b0, frac_acc_r} + {1'b0, frac_cur_r};

   // Fraction accumulator: a carry out stretches the following os period by one cycle.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         frac_cur_r <= {FRAC_W{1'b0}};
         frac_acc_r <= {FRAC_W{1'b0}};
         stretch_r  <= 1'b0;
      end else if (div_ld) begin
         frac_cur_r <= frac_in;
         frac_acc_r <= {FRAC_W{1'b0}};
         stretch_r  <= 1'b0;
      end else if (os_term_s) begin
         frac_cur_r <= frac_cur_r;
         frac_acc_r <= frac_sum_s[FRAC_W-1:0];
         stretch_r  <= frac_sum_s[FRAC_W];
      end else begin
         frac_cur_r <= frac_cur_r;
         frac_acc_r <= frac_acc_r;
         stretch_r  <= stretch_r;
      end
   end

   // Terminal value of the os counter, one higher during a stretched period.
   always_comb begin
      os_last_s = div_cur_r - DIV_W'(1);
      if (stretch_r) begin
         os_last_s = div_cur_r;
      end else begin
         os_last_s = div_cur_r - DIV_W'(1);
      end
   end
`else
   logic [FRAC_W-1:0] unused_frac_s;
   assign unused_frac_s = frac_in;

   // Terminal value of the os counter; div_cur is never zero so no underflow.
   always_comb begin
      os_last_s = div_cur_r - DIV_W'(1);
   end
`endif

   uart_mod_counter #(.W(DIV_W)) u_os_cnt (
      .sys_clk (sys_clk),
      .reset   (reset),
      .en      (en),
      .clr     (div_ld),
      .last    (os_last_s),
      .term    (os_term_s)
   );

   uart_mod_counter #(.W(BIT_W)) u_bit_cnt (
      .sys_clk (sys_clk),
      .reset   (reset),
      .en      (os_term_s),
      .clr     (div_ld),
      .last    (BIT_LAST),
      .term    (bit_term_s)
   );

   // Divisor and tick registers; a load restarts phase and suppresses a coincident tick.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         div_cur_r  <= DEF_DIV;
         os_tick_r  <= 1'b0;
         bit_tick_r <= 1'b0;
      end else if (div_ld) begin
         div_cur_r  <= div_load_val_s;
         os_tick_r  <= 1'b0;
         bit_tick_r <= 1'b0;
      end else begin
         div_cur_r  <= div_cur_r;
         os_tick_r  <= os_term_s;
         bit_tick_r <= bit_term_s;
      end
   end

   assign os_tick  = os_tick_r;
   assign bit_tick = bit_tick_r;
   assign div_cur  = div_cur_r;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen with a per-cycle expected-output scoreboard.
module tb_uart_baud_gen;

   localparam int DIV_W  = 16;
   localparam int FRAC_W = 4;
   localparam int OS     = 4;
`ifdef UART_BAUD_FRAC_EN
   localparam bit FRAC_ON = 1'b1;
`else
   localparam bit FRAC_ON = 1'b0;
`endif

   logic              sys_clk = 1'b0;
   logic              reset;
   logic              en;
   logic              div_ld;
   logic [DIV_W-1:0]  div_in;
   logic [FRAC_W-1:0] frac_in;
   logic              os_tick;
   logic              bit_tick;
   logic [DIV_W-1:0]  div_cur;

   typedef struct packed {
      logic             os;
      logic             bt;
      logic [DIV_W-1:0] div;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   m_os, m_bit, m_div, m_acc, m_frac, m_stretch;
   int   k, os_seen, bit_seen, first_os, first_bit;

   always #5 sys_clk = ~sys_clk;

   uart_baud_gen #(
      .SYS_CLK_FREQ (1_000_000),
      .DEFAULT_BAUD (62500),
      .OVERSAMPLE   (OS),
      .DIV_W        (DIV_W),
      .FRAC_W       (FRAC_W)
   ) dut (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .en       (en),
      .div_ld   (div_ld),
      .div_in   (div_in),
      .frac_in  (frac_in),
      .os_tick  (os_tick),
      .bit_tick (bit_tick),
      .div_cur  (div_cur)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Reference: positional model of the counters, evaluated for the coming edge.
   task automatic model_push();
      exp_t e;
      int   per;
      e.os = 1'b0;
      e.bt = 1'b0;
      if (reset) begin
         m_os = 0; m_bit = 0; m_acc = 0; m_frac = 0; m_stretch = 0; m_div = 4;
      end else if (div_ld) begin
         m_div = (div_in == 16'd0) ? 1 : int'(div_in);
         m_frac = FRAC_ON ? int'(frac_in) : 0;
         m_os = 0; m_bit = 0; m_acc = 0; m_stretch = 0;
      end else if (en) begin
         per = m_div + m_stretch;
         if (m_os == per - 1) begin
            e.os = 1'b1;
            e.bt = (m_bit == OS - 1);
            m_bit = (m_bit + 1) % OS;
            m_os = 0;
            m_acc = m_acc + m_frac;
            m_stretch = (m_acc >= 16) ? 1 : 0;
            m_acc = m_acc % 16;
         end else begin
            m_os++;
         end
      end
      e.div = DIV_W'(m_div);
      exp_q.push_back(e);
   endtask

   task automatic cycle();
      exp_t e;
      model_push();
      @(posedge sys_clk);
      #1;
      k++;
      e = exp_q.pop_front();
      chk("os_tick", 32'(os_tick), 32'(e.os));
      chk("bit_tick", 32'(bit_tick), 32'(e.bt));
      chk("div_cur", 32'(div_cur), 32'(e.div));
      if (os_tick === 1'b1) begin
         os_seen++;
         if (first_os < 0) first_os = k;
      end
      if (bit_tick === 1'b1) begin
         bit_seen++;
         if (first_bit < 0) first_bit = k;
      end
   endtask

   task automatic mark();
      k = 0; os_seen = 0; bit_seen = 0; first_os = -1; first_bit = -1;
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; div_ld = 1'b0; div_in = 16'd0; frac_in = 4'd0;
      mark();
      repeat (2) cycle();
      chk("rst_div_cur", 32'(div_cur), 32'd4);
      chk("rst_os_tick", 32'(os_tick), 32'd0);

      // 1: free run from reset
      reset = 1'b0; en = 1'b1;
      mark();
      repeat (40) cycle();
      chk("t1_os_count", os_seen, 32'd10);
      chk("t1_bit_count", bit_seen, 32'd2);
      chk("t1_first_os", first_os, 32'd4);
      chk("t1_first_bit", first_bit, 32'd16);

      // 2: load 6 mid-period
      repeat (2) cycle();
      div_ld = 1'b1; div_in = 16'd6;
      cycle();
      div_ld = 1'b0;
      chk("t2_ld_os", 32'(os_tick), 32'd0);
      chk("t2_ld_bit", 32'(bit_tick), 32'd0);
      chk("t2_div_cur", 32'(div_cur), 32'd6);
      mark();
      repeat (24) cycle();
      chk("t2_first_os", first_os, 32'd6);
      chk("t2_first_bit", first_bit, 32'd24);
      chk("t2_os_count", os_seen, 32'd4);

      // load landing on a terminal-count edge suppresses that tick
      repeat (5) cycle();
      div_ld = 1'b1; div_in = 16'd4;
      cycle();
      div_ld = 1'b0;
      chk("t2_ld_tc_os", 32'(os_tick), 32'd0);
      chk("t2_ld_tc_div", 32'(div_cur), 32'd4);
      repeat (2) cycle();

      // 3: hold with en=0 at os_cnt=2
      en = 1'b0;
      mark();
      repeat (10) cycle();
      chk("t3_hold_os", os_seen, 32'd0);
      chk("t3_hold_bit", bit_seen, 32'd0);
      en = 1'b1;
      mark();
      repeat (4) cycle();
      chk("t3_resume_first_os", first_os, 32'd2);
      chk("t3_resume_os_count", os_seen, 32'd1);

      // 4: zero divisor loads as 1
      div_ld = 1'b1; div_in = 16'd0;
      cycle();
      div_ld = 1'b0;
      chk("t4_div_cur", 32'(div_cur), 32'd1);
      mark();
      repeat (8) cycle();
      chk("t4_os_count", os_seen, 32'd8);
      chk("t4_bit_count", bit_seen, 32'd2);
      chk("t4_first_bit", first_bit, 32'd4);

`ifdef UART_BAUD_FRAC_EN
      // 5: fractional divisor 4 + 8/16
      div_ld = 1'b1; div_in = 16'd4; frac_in = 4'd8;
      cycle();
      div_ld = 1'b0; frac_in = 4'd0;
      mark();
      repeat (144) cycle();
      chk("t5_os_count", os_seen, 32'd32);
      chk("t5_bit_count", bit_seen, 32'd8);
`endif

      // 6: reset 3 cycles before a bit_tick after a non-default load
      div_ld = 1'b1; div_in = 16'd5; frac_in = 4'd0;
      cycle();
      div_ld = 1'b0;
      chk("t6_ld_div", 32'(div_cur), 32'd5);
      mark();
      repeat (16) cycle();
      chk("t6_pre_bit_count", bit_seen, 32'd0);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("t6_rst_os", 32'(os_tick), 32'd0);
      chk("t6_rst_bit", 32'(bit_tick), 32'd0);
      chk("t6_rst_div", 32'(div_cur), 32'd4);
      mark();
      repeat (16) cycle();
      chk("t6_first_os", first_os, 32'd4);
      chk("t6_first_bit", first_bit, 32'd16);
      chk("t6_os_count", os_seen, 32'd4);

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
